// File: rtl/i2c_master_regs_fifo_pkg.sv
// Shared defines for the I2C master register block: register addresses,
// CTR/CR/SR/ERR bit positions and auto-write sequencer states.
package i2c_master_regs_fifo_pkg;

  localparam logic [2:0] I2C_PRER = 3'd0;
  localparam logic [2:0] I2C_CTR  = 3'd1;
  localparam logic [2:0] I2C_TXR  = 3'd2;
  localparam logic [2:0] I2C_CR   = 3'd3;
  localparam logic [2:0] I2C_RXR  = 3'd4;
  localparam logic [2:0] I2C_SR   = 3'd5;
  localparam logic [2:0] I2C_LVL  = 3'd6;
  localparam logic [2:0] I2C_ERR  = 3'd7;

  localparam int CTR_EN     = 7;
  localparam int CTR_IEN    = 6;
  localparam int CTR_TXE_IE = 5;
  localparam int CTR_RXT_IE = 4;
  localparam int CTR_AUTO   = 3;

  localparam int CR_STA   = 7;
  localparam int CR_STO   = 6;
  localparam int CR_RD    = 5;
  localparam int CR_WR    = 4;
  localparam int CR_ACK   = 3;
  localparam int CR_FLUSH = 2;
  localparam int CR_IACK  = 0;

  localparam int SR_RXACK   = 7;
  localparam int SR_BUSY    = 6;
  localparam int SR_AL      = 5;
  localparam int SR_TXFULL  = 4;
  localparam int SR_TXEMPTY = 3;
  localparam int SR_RXNE    = 2;
  localparam int SR_TIP     = 1;
  localparam int SR_IF      = 0;

  localparam int ERR_TXOVF = 1;
  localparam int ERR_RXOVF = 0;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_XFER = 2'd1,
    SEQ_GAP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous byte FIFO with flush; head reads 0 when empty, ovf pulses on a dropped push.
module i2c_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~pop;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2c_master_regs_fifo.sv
// I2C master register block with TX/RX byte FIFOs, auto-write streaming,
// level/overflow reporting and maskable interrupt sources.
module i2c_master_regs_fifo
  import i2c_master_regs_fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 3,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  parameter int RX_THRESH = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [AWIDTH-1:0] Addr,
  input  logic [DWIDTH-1:0] DataIn,
  output logic [DWIDTH-1:0] DataOut,
  input  logic              Wr,
  input  logic              Rd,
  output logic              Int,
  output logic              Start,
  output logic              Stop,
  output logic              Read,
  output logic              Write,
  output logic              Tx_ack,
  input  logic              Rx_ack,
  input  logic [7:0]        Rx_data,
  output logic [7:0]        Tx_data,
  output logic [7:0]        Prescale,
  input  logic              I2C_busy,
  input  logic              I2C_done,
  input  logic              I2C_al,
  output logic              I2C_en
);
  localparam int TCW = $clog2(TX_DEPTH + 1);
  localparam int RCW = $clog2(RX_DEPTH + 1);

  logic [7:0]     prer, ctr, sr, tx_head, rx_head;
  logic           cr_sta, cr_sto, cr_rd, cr_wr, cr_ack;
  logic           al, rxack, irq_flag, int_q, txovf, rxovf;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count, rx_count_q;
  logic           tx_full, tx_empty, tx_empty_q, tx_ovf, rx_full, rx_empty, rx_ovf;
  logic           wr_prer, wr_ctr, wr_txr, wr_cr, wr_err, rd_rxr, flush_wr, iack_wr;
  logic           tx_more, abort, seq_reassert, mid_done, if_set;
  seq_state_e     state, state_n;

  assign wr_prer  = Wr && (Addr == AWIDTH'(I2C_PRER));
  assign wr_ctr   = Wr && (Addr == AWIDTH'(I2C_CTR));
  assign wr_txr   = Wr && (Addr == AWIDTH'(I2C_TXR));
  assign wr_cr    = Wr && (Addr == AWIDTH'(I2C_CR));
  assign wr_err   = Wr && (Addr == AWIDTH'(I2C_ERR));
  assign rd_rxr   = Rd && (Addr == AWIDTH'(I2C_RXR));
  // FLUSH/IACK act during the write cycle itself and are never stored
  assign flush_wr = wr_cr & DataIn[CR_FLUSH];
  assign iack_wr  = wr_cr & DataIn[CR_IACK];

  i2c_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(Clk), .rst(Rst), .flush(flush_wr), .push(wr_txr), .pop(I2C_done & cr_wr),
    .din(DataIn[7:0]), .head(tx_head), .count(tx_count), .full(tx_full),
    .empty(tx_empty), .ovf(tx_ovf)
  );

  i2c_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(Clk), .rst(Rst), .flush(flush_wr), .push(I2C_done & cr_rd), .pop(rd_rxr),
    .din(Rx_data), .head(rx_head), .count(rx_count), .full(rx_full),
    .empty(rx_empty), .ovf(rx_ovf)
  );

  // TX still holds a byte once the current done pops its head
  assign tx_more = (tx_count > TCW'(1)) | wr_txr;
  assign abort   = I2C_al | ~ctr[CTR_AUTO] | flush_wr;

  always_ff @(posedge Clk) begin
    if (Rst) state <= SEQ_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    seq_reassert = 1'b0;
    mid_done     = 1'b0;
    case (state)
      SEQ_IDLE: if (cr_wr && !abort && !I2C_done) state_n = SEQ_XFER;
      SEQ_XFER: begin
        if (abort) state_n = SEQ_IDLE;
        else if (I2C_done) begin
          if (tx_more && !cr_sto) begin
            state_n  = SEQ_GAP;
            mid_done = 1'b1;
          end else begin
            state_n = SEQ_IDLE;
          end
        end
      end
      SEQ_GAP: begin
        if (abort) state_n = SEQ_IDLE;
        else begin
          seq_reassert = 1'b1;
          state_n      = SEQ_XFER;
        end
      end
      default: state_n = SEQ_IDLE;
    endcase
  end

  assign if_set = (I2C_done & ~mid_done) | I2C_al
                | (ctr[CTR_TXE_IE] & tx_empty & ~tx_empty_q)
                | (ctr[CTR_RXT_IE] & (rx_count == RCW'(RX_THRESH)) & (rx_count_q != RCW'(RX_THRESH)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prer       <= '0;
      ctr        <= '0;
      {cr_sta, cr_sto, cr_rd, cr_wr, cr_ack} <= '0;
      al         <= 1'b0;
      rxack      <= 1'b0;
      irq_flag   <= 1'b0;
      int_q      <= 1'b0;
      txovf      <= 1'b0;
      rxovf      <= 1'b0;
      tx_empty_q <= 1'b1;
      rx_count_q <= '0;
    end else begin
      if (wr_prer) prer <= DataIn[7:0];
      if (wr_ctr)  ctr  <= {DataIn[7:3], 3'b000};
      if (I2C_done || I2C_al) {cr_sta, cr_sto, cr_rd, cr_wr} <= '0;
      if (seq_reassert) begin
        cr_wr  <= 1'b1;
        cr_sta <= 1'b0;
      end
      if (wr_cr) {cr_sta, cr_sto, cr_rd, cr_wr, cr_ack} <= DataIn[7:3];
      if (I2C_done) rxack <= Rx_ack;
      if (I2C_al) al <= 1'b1;
      else if (iack_wr) al <= 1'b0;
      if (if_set) irq_flag <= 1'b1;
      else if (iack_wr) irq_flag <= 1'b0;
      int_q <= irq_flag & ctr[CTR_IEN];
      if (flush_wr) txovf <= 1'b0;
      else if (tx_ovf) txovf <= 1'b1;
      else if (wr_err && DataIn[ERR_TXOVF]) txovf <= 1'b0;
      if (flush_wr) rxovf <= 1'b0;
      else if (rx_ovf) rxovf <= 1'b1;
      else if (wr_err && DataIn[ERR_RXOVF]) rxovf <= 1'b0;
      tx_empty_q <= tx_empty;
      rx_count_q <= rx_count;
    end
  end

  always_comb begin
    sr             = '0;
    sr[SR_RXACK]   = rxack;
    sr[SR_BUSY]    = I2C_busy;
    sr[SR_AL]      = al;
    sr[SR_TXFULL]  = tx_full;
    sr[SR_TXEMPTY] = tx_empty;
    sr[SR_RXNE]    = ~rx_empty;
    sr[SR_TIP]     = cr_rd | cr_wr;
    sr[SR_IF]      = irq_flag;
  end

  always_comb begin
    DataOut = '0;
    case (Addr)
      AWIDTH'(I2C_PRER): DataOut = prer;
      AWIDTH'(I2C_CTR):  DataOut = ctr;
      AWIDTH'(I2C_TXR):  DataOut = tx_head;
      AWIDTH'(I2C_CR):   DataOut = {cr_sta, cr_sto, cr_rd, cr_wr, cr_ack, 3'b000};
      AWIDTH'(I2C_RXR):  DataOut = rx_head;
      AWIDTH'(I2C_SR):   DataOut = sr;
      AWIDTH'(I2C_LVL):  DataOut = {4'(tx_count), 4'(rx_count)};
      AWIDTH'(I2C_ERR):  DataOut = {6'b000000, txovf, rxovf};
      default:           DataOut = '0;
    endcase
  end

  assign Int      = int_q;
  assign Start    = cr_sta;
  assign Stop     = cr_sto;
  assign Read     = cr_rd;
  assign Write    = cr_wr;
  assign Tx_ack   = cr_ack;
  assign Tx_data  = tx_head;
  assign Prescale = prer;
  assign I2C_en   = ctr[CTR_EN];

endmodule

// File: tb/tb_i2c_master_regs_fifo.sv
// Bench for i2c_master_regs_fifo: directed scenarios plus randomized FIFO traffic
// checked against queue-based reference behaviour.
module tb_i2c_master_regs_fifo;
  logic       Clk = 1'b0, Rst = 1'b1;
  logic [2:0] Addr = '0;
  logic [7:0] DataIn = '0, DataOut;
  logic       Wr = 1'b0, Rd = 1'b0, Int;
  logic       Start, Stop, Read, Write, Tx_ack;
  logic       Rx_ack = 1'b0;
  logic [7:0] Rx_data = '0, Tx_data, Prescale;
  logic       I2C_busy = 1'b0, I2C_done = 1'b0, I2C_al = 1'b0, I2C_en;
  int         checks = 0, failures = 0;

  i2c_master_regs_fifo #(.DWIDTH(8), .AWIDTH(3), .TX_DEPTH(4), .RX_DEPTH(4), .RX_THRESH(1)) dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .Wr(Wr), .Rd(Rd),
    .Int(Int), .Start(Start), .Stop(Stop), .Read(Read), .Write(Write), .Tx_ack(Tx_ack),
    .Rx_ack(Rx_ack), .Rx_data(Rx_data), .Tx_data(Tx_data), .Prescale(Prescale),
    .I2C_busy(I2C_busy), .I2C_done(I2C_done), .I2C_al(I2C_al), .I2C_en(I2C_en)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // all tasks start and finish at a falling edge
  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst = 1'b1; Wr = 1'b0; Rd = 1'b0; I2C_done = 1'b0; I2C_al = 1'b0; I2C_busy = 1'b0;
    cycles(2);
    Rst = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    Addr = a; DataIn = d; Wr = 1'b1;
    @(negedge Clk);
    Wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    Addr = a;
    #1 d = DataOut;
  endtask

  task automatic pop_rxr(output logic [7:0] d);
    Addr = 3'd4; Rd = 1'b1;
    #1 d = DataOut;
    @(negedge Clk);
    Rd = 1'b0;
  endtask

  task automatic pulse_done();
    I2C_done = 1'b1;
    @(negedge Clk);
    I2C_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), d);
      e = (a == 5) ? 8'h08 : 8'h00;
      if (d !== e) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", a, d, e); end
      checks++;
    end
    if ({Int, Start, Stop, Read, Write, Tx_ack, I2C_en} !== 7'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {Int, Start, Stop, Read, Write, Tx_ack, I2C_en});
    end
    checks++;
    if ({Tx_data, Prescale} !== 16'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0000", {Tx_data, Prescale});
    end
    checks++;
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d;
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    wr_reg(3'd0, 8'h5A);
    if (Prescale !== 8'h5A) begin failures++; $display("FAIL prescale got=%h exp=5a", Prescale); end
    checks++;
    foreach (bytes[i]) wr_reg(3'd2, bytes[i]);
    rd_reg(3'd6, d);
    if (d !== 8'h40) begin failures++; $display("FAIL ovf_lvl got=%h exp=40", d); end
    checks++;
    rd_reg(3'd5, d);
    if (d[4] !== 1'b1) begin failures++; $display("FAIL ovf_txfull got=%b exp=1", d[4]); end
    checks++;
    rd_reg(3'd7, d);
    if (d !== 8'h02) begin failures++; $display("FAIL ovf_err got=%h exp=02", d); end
    checks++;
    if (Tx_data !== 8'h11) begin failures++; $display("FAIL ovf_head got=%h exp=11", Tx_data); end
    checks++;
    wr_reg(3'd7, 8'h02);
    rd_reg(3'd7, d);
    if (d !== 8'h00) begin failures++; $display("FAIL err_w1c got=%h exp=00", d); end
    checks++;
  endtask

  task automatic test_random_fifo();
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic       txovf = 1'b0, rxovf = 1'b0, rxack = 1'b0;
    logic [7:0] b, d, e;
    int         op;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 5);
      I2C_busy = 1'($urandom_range(0, 1));
      case (op)
        0, 5: begin
          b = 8'($urandom);
          wr_reg(3'd2, b);
          if (txq.size() < 4) txq.push_back(b); else txovf = 1'b1;
        end
        1: begin
          b = 8'($urandom);
          wr_reg(3'd3, 8'h20);
          Rx_data = b; Rx_ack = 1'($urandom_range(0, 1));
          pulse_done();
          rxack = Rx_ack;
          if (rxq.size() < 4) rxq.push_back(b); else rxovf = 1'b1;
        end
        2: begin
          pop_rxr(d);
          e = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
          if (d !== e) begin failures++; $display("FAIL rnd_rxr i=%0d got=%h exp=%h", i, d, e); end
          checks++;
        end
        3: begin
          wr_reg(3'd3, 8'h10);
          Rx_ack = 1'($urandom_range(0, 1));
          pulse_done();
          rxack = Rx_ack;
          if (txq.size() > 0) void'(txq.pop_front());
        end
        default: begin
          b = 8'($urandom_range(0, 3));
          wr_reg(3'd7, b);
          if (b[1]) txovf = 1'b0;
          if (b[0]) rxovf = 1'b0;
        end
      endcase
      rd_reg(3'd6, d);
      e = {4'(txq.size()), 4'(rxq.size())};
      if (d !== e) begin failures++; $display("FAIL rnd_lvl i=%0d got=%h exp=%h", i, d, e); end
      checks++;
      e = (txq.size() > 0) ? txq[0] : 8'h00;
      if (Tx_data !== e) begin failures++; $display("FAIL rnd_txdata i=%0d got=%h exp=%h", i, Tx_data, e); end
      checks++;
      rd_reg(3'd7, d);
      if (d !== {6'b0, txovf, rxovf}) begin
        failures++; $display("FAIL rnd_err i=%0d got=%h exp=%h", i, d, {6'b0, txovf, rxovf});
      end
      checks++;
      rd_reg(3'd5, d);
      if (d[7:6] !== {rxack, I2C_busy}) begin
        failures++; $display("FAIL rnd_sr i=%0d got=%b exp=%b", i, d[7:6], {rxack, I2C_busy});
      end
      checks++;
    end
    I2C_busy = 1'b0;
  endtask

  task automatic test_auto_stream();
    logic [7:0] d;
    logic [7:0] bq [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    wr_reg(3'd1, 8'h08);
    foreach (bq[i]) wr_reg(3'd2, bq[i]);
    wr_reg(3'd3, 8'h90);
    cycles(2);
    for (int k = 0; k < 3; k++) begin
      if (Tx_data !== bq[k]) begin failures++; $display("FAIL auto_txdata k=%0d got=%h exp=%h", k, Tx_data, bq[k]); end
      checks++;
      if (Write !== 1'b1 || Start !== (k == 0)) begin
        failures++; $display("FAIL auto_cmd k=%0d got=%b%b exp=1%b", k, Write, Start, k == 0);
      end
      checks++;
      pulse_done();
      rd_reg(3'd5, d);
      if (k < 2) begin
        if (Write !== 1'b0) begin failures++; $display("FAIL auto_gap k=%0d got=%b exp=0", k, Write); end
        checks++;
        if (d[0] !== 1'b0) begin failures++; $display("FAIL auto_if_mid k=%0d got=%b exp=0", k, d[0]); end
        checks++;
        cycles(1);
      end else begin
        if (d[0] !== 1'b1) begin failures++; $display("FAIL auto_if_last got=%b exp=1", d[0]); end
        checks++;
      end
    end
    cycles(3);
    if (Write !== 1'b0 || Tx_data !== 8'h00) begin
      failures++; $display("FAIL auto_end got=%b/%h exp=0/00", Write, Tx_data);
    end
    checks++;
  endtask

  task automatic test_rx_irq();
    logic [7:0] d;
    do_reset();
    wr_reg(3'd1, 8'h50);
    wr_reg(3'd3, 8'h20);
    Rx_data = 8'hA5; Rx_ack = 1'b1;
    pulse_done();
    Rx_ack = 1'b0;
    if (Int !== 1'b0) begin failures++; $display("FAIL rx_int_early got=%b exp=0", Int); end
    checks++;
    cycles(1);
    if (Int !== 1'b1) begin failures++; $display("FAIL rx_int got=%b exp=1", Int); end
    checks++;
    rd_reg(3'd5, d);
    if (d[7] !== 1'b1 || Read !== 1'b0) begin
      failures++; $display("FAIL rx_sr got=%b%b exp=10", d[7], Read);
    end
    checks++;
    pop_rxr(d);
    if (d !== 8'hA5) begin failures++; $display("FAIL rx_data got=%h exp=a5", d); end
    checks++;
    wr_reg(3'd3, 8'h01);
    cycles(1);
    if (Int !== 1'b0) begin failures++; $display("FAIL rx_iack got=%b exp=0", Int); end
    checks++;
  endtask

  task automatic test_arb_lost();
    logic [7:0] d;
    do_reset();
    wr_reg(3'd1, 8'h08);
    wr_reg(3'd2, 8'h66);
    wr_reg(3'd2, 8'h77);
    wr_reg(3'd3, 8'h90);
    cycles(2);
    I2C_al = 1'b1;
    @(negedge Clk);
    I2C_al = 1'b0;
    rd_reg(3'd3, d);
    if (d !== 8'h00) begin failures++; $display("FAIL al_cr got=%h exp=00", d); end
    checks++;
    rd_reg(3'd5, d);
    if (d !== 8'h21) begin failures++; $display("FAIL al_sr got=%h exp=21", d); end
    checks++;
    cycles(3);
    if (Write !== 1'b0 || Start !== 1'b0) begin
      failures++; $display("FAIL al_idle got=%b%b exp=00", Write, Start);
    end
    checks++;
    wr_reg(3'd3, 8'h01);
    rd_reg(3'd5, d);
    if (d !== 8'h00) begin failures++; $display("FAIL al_iack got=%h exp=00", d); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    do_reset();
    pulse_done();
    Addr = 3'd3; DataIn = 8'h01; Wr = 1'b1; I2C_done = 1'b1;
    @(negedge Clk);
    Wr = 1'b0; I2C_done = 1'b0;
    rd_reg(3'd5, d);
    if (d[0] !== 1'b1) begin failures++; $display("FAIL if_set_wins got=%b exp=1", d[0]); end
    checks++;
    wr_reg(3'd3, 8'h01);
    rd_reg(3'd5, d);
    if (d[0] !== 1'b0) begin failures++; $display("FAIL if_iack got=%b exp=0", d[0]); end
    checks++;
    for (int i = 0; i < 5; i++) wr_reg(3'd2, 8'(i + 1));
    for (int i = 0; i < 5; i++) begin
      wr_reg(3'd3, 8'h20);
      Rx_data = 8'(8'hC0 + i);
      pulse_done();
    end
    rd_reg(3'd6, d);
    if (d !== 8'h44) begin failures++; $display("FAIL full_lvl got=%h exp=44", d); end
    checks++;
    rd_reg(3'd7, d);
    if (d !== 8'h03) begin failures++; $display("FAIL full_err got=%h exp=03", d); end
    checks++;
    wr_reg(3'd3, 8'h04);
    rd_reg(3'd6, d);
    if (d !== 8'h00) begin failures++; $display("FAIL flush_lvl got=%h exp=00", d); end
    checks++;
    rd_reg(3'd7, d);
    if (d !== 8'h00) begin failures++; $display("FAIL flush_err got=%h exp=00", d); end
    checks++;
    wr_reg(3'd1, 8'h88);
    wr_reg(3'd2, 8'h99);
    wr_reg(3'd3, 8'h90);
    cycles(2);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    if ({Start, Write, I2C_en, Tx_data} !== 11'h0) begin
      failures++; $display("FAIL midrst_out got=%h exp=000", {Start, Write, I2C_en, Tx_data});
    end
    checks++;
    rd_reg(3'd5, d);
    if (d !== 8'h08) begin failures++; $display("FAIL midrst_sr got=%h exp=08", d); end
    checks++;
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_tx_overflow();
    test_random_fifo();
    test_auto_stream();
    test_rx_irq();
    test_arb_lost();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_master_regs_fifo.md
Name: i2c_master_regs_fifo

Overview:
Next-generation register block for the I2C master core. It keeps the same processor-bus and core-command interface as the current register block and adds parametrised TX and RX byte FIFOs. An auto-write mode streams queued bytes to the core without CPU involvement between bytes. It also adds FIFO level, threshold and overflow reporting with maskable interrupt sources.

Parameters:
DWIDTH, 8, bus data width; only 8 supported.
AWIDTH, 3, bus address width.
TX_DEPTH, 4, TX FIFO entries; power of 2, 2..8.
RX_DEPTH, 4, RX FIFO entries; power of 2, 2..8.
RX_THRESH, 2, RX level (1..RX_DEPTH) that raises the RX interrupt source.

Ports:
Clk  in  1  system clock; all state on rising edge.
Rst  in  1  synchronous reset, active-high.
Addr  in  AWIDTH  register address.
DataIn  in  DWIDTH  bus write data.
DataOut  out  DWIDTH  bus read data, combinational from Addr.
Wr  in  1  write strobe, one cycle per access.
Rd  in  1  read strobe; side effects (RXR pop) only.
Int  out  1  interrupt request.
Start, Stop, Read, Write, Tx_ack  out  1 each  command bits to core.
Rx_ack  in  1  ACK received from slave.
Rx_data  in  8  byte received by core, valid with I2C_done.
Tx_data  out  8  TX FIFO head; 0 when empty.
Prescale  out  8  clock prescale.
I2C_busy, I2C_done, I2C_al  in  1 each  core status: busy level, done pulse, arbitration-lost pulse.
I2C_en  out  1  core enable.

Behaviour:
- Register map:
  - 0 PRER: RW.
  - 1 CTR: RW. [7] EN, [6] IEN, [5] TXE_IE, [4] RXT_IE, [3] AUTO; [2:0] read 0.
  - 2 TXR: write pushes the TX FIFO; read returns the head without popping.
  - 3 CR: [7] STA, [6] STO, [5] RD, [4] WR, [3] ACK, [2] FLUSH, [0] IACK. Reads return [7:3]; [2:0] read 0.
  - 4 RXR: read with Rd pops the RX FIFO and returns the head; when empty, returns 0 and does not pop.
  - 5 SR: [7] RxACK, [6] BUSY, [5] AL, [4] TXFULL, [3] TXEMPTY, [2] RXNE, [1] TIP, [0] IF.
  - 6 LVL: [7:4] TX count, [3:0] RX count.
  - 7 ERR: [1] TXOVF, [0] RXOVF; write 1 to clear.
- Reset values: all registers 0; both FIFOs empty (SR reads 0x08).
  - Outputs: DataOut = 0x00 at Addr 0, 1, 2 and 3; Int 0; all commands 0; Tx_data 0; Prescale 0; I2C_en 0.
- Command outputs are direct from CR bits: Start, Stop, Read, Write, Tx_ack.
- TIP = RD | WR.
- CR auto-clear of STA/STO/RD/WR on I2C_done or I2C_al, in the next cycle. ACK is kept.
- FLUSH and IACK self-clear after one cycle.
  - FLUSH empties both FIFOs and clears TXOVF/RXOVF.
- On I2C_done:
  - RxACK <= Rx_ack.
  - If RD was set, Rx_data is pushed to RX.
  - If WR was set, TX is popped.
- On I2C_al: AL set; cleared only by writing CR with IACK=1.
- FIFO rules:
  - Push while full: byte dropped, xxOVF set.
  - Pop while empty: no-op.
  - Simultaneous push and pop while full (TX): both take effect; count unchanged.
  - Simultaneous push and pop while empty: the pop is ignored and the push takes effect.
  - Pointers wrap modulo depth.
- AUTO sequencer states: IDLE, XFER, GAP.
  - IDLE -> XFER when WR is set and AUTO=1.
  - XFER on I2C_done:
    - if TX is non-empty after the pop and STO=0: -> GAP, where WR re-asserts after one cycle gap with STA cleared, then -> XFER;
    - otherwise -> IDLE.
  - Any state -> IDLE on I2C_al, on AUTO=0 or on FLUSH.
- IF sources:
  - I2C_done, except the intermediate dones of an auto stream;
  - I2C_al;
  - TXEMPTY rising edge when TXE_IE=1;
  - RX count reaching RX_THRESH when RXT_IE=1.
- IF clearing: IACK clears IF. A set event in the same cycle as IACK wins.
- Int = IF & IEN, registered.
- Rst mid-transfer returns everything to reset values in the next cycle.

Decomposition:
- Shared define file i2c_master_defines: register addresses I2C_PRER..I2C_ERR, CTR/CR/SR bit indices, sequencer state encodings.
- One sub-module i2c_sync_fifo (params DEPTH, WIDTH). It provides push, pop, head, count, full, empty and overflow pulse, and is instantiated twice.

Test Plan:
- Reset then read all addresses -> 0x00 except SR=0x08; Int=0.
- Push 0x11,0x22,0x33,0x44,0x55 with TX_DEPTH=4 -> LVL[7:4]=4, TXFULL=1, ERR=0x02, Tx_data=0x11.
- AUTO=1, 3 bytes queued, write CR=0x90, pulse I2C_done ×3 -> Write re-asserts after a 1-cycle gap; Start=0 after the first byte; Tx_data 0x11→0x22→0x33; IF set only after the third done.
- CR=0x20, I2C_done with Rx_data=0xA5 and Rx_ack=1, RX_THRESH=1, RXT_IE=1, IEN=1 -> RXR=0xA5, SR[7]=1, Int=1 two cycles later; IACK -> Int=0.
- I2C_al during XFER -> CR command bits=0, SR=0x21 (AL and IF set), sequencer IDLE; CR IACK clears AL.
- I2C_done coincident with IACK write -> IF stays 1; FLUSH with full FIFOs -> LVL=0x00, ERR=0x00.
